// File: rtl/seg_scan_reader.sv
// ---------------------------------------------------------------------------
// seg_scan_reader
//
// Reads a multiplexed 7-segment display bus back into a hex value. The bus is
// sampled every clock. A segment pattern is accepted for digit k only after
// it has been seen on STABLE_CYCLES consecutive identical cycles while
// i_digitSel is one-hot. Accepted patterns are decoded to a nibble. When every
// digit position has been captured, the assembled value is presented with a
// valid/ready handshake.
//
// Optional feature: define SEG_SCAN_READER_DP_EN to add o_dpMask. With the
// feature enabled, the decimal-point line is part of the stability compare.
// Without it, the decimal-point line is ignored completely.
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_segs       segment lines {dp,f,g,e,d,c,b,a}, active-high
//   i_digitSel   one-hot digit select, bit k = digit k (digit 0 = LS nibble)
//   o_value      assembled hex value, 4 bits per digit
//   o_errMask    bit k set = digit k pattern not in decode table
//   o_dpMask     (SEG_SCAN_READER_DP_EN only) dp line at digit k's capture
//   o_valid      frame valid
//   i_ready      consumer accepts frame
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_COLLECT | capturing stable digits until every position is filled
// ST_PRESENT | frame held on outputs with o_valid=1 until i_ready
// ---------------------------------------------------------------------------
module seg_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [7:0]              i_segs,
  input  logic [NUM_DIGITS-1:0]   i_digitSel,
  output logic [4*NUM_DIGITS-1:0] o_value,
  output logic [NUM_DIGITS-1:0]   o_errMask,
`ifdef SEG_SCAN_READER_DP_EN
  output logic [NUM_DIGITS-1:0]   o_dpMask,
`endif
  output logic                    o_valid,
  input  logic                    i_ready
);

`ifdef SEG_SCAN_READER_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif

  // Run counter saturates at STABLE_CYCLES-1; the capture happens on the
  // single edge that moves it from STABLE_CYCLES-2 to STABLE_CYCLES-1.
  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_FIRE = 8'(STABLE_CYCLES - 2);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SEG_W-1:0]        seg_prev_q, seg_prev_d;
  logic [NUM_DIGITS-1:0]   sel_prev_q, sel_prev_d;
  logic [7:0]              run_cnt_q, run_cnt_d;
  logic [NUM_DIGITS-1:0]   captured_q, captured_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;

  logic [SEG_W-1:0]      segs_cmp;
  logic                  sel_onehot;
  logic                  run_match;
  logic                  cap_fire;
  logic                  cap_en;
  logic [NUM_DIGITS-1:0] captured_next;
  logic                  all_captured;
  logic [3:0]            dec_nib;
  logic                  dec_err;

  // Returns {err, nibble}; bit7 (dp) never takes part in the match.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h5f:   res = {1'b0, 4'h0};
      7'h06:   res = {1'b0, 4'h1};
      7'h3b:   res = {1'b0, 4'h2};
      7'h2f:   res = {1'b0, 4'h3};
      7'h66:   res = {1'b0, 4'h4};
      7'h6d:   res = {1'b0, 4'h5};
      7'h7d:   res = {1'b0, 4'h6};
      7'h07:   res = {1'b0, 4'h7};
      7'h7f:   res = {1'b0, 4'h8};
      7'h6f:   res = {1'b0, 4'h9};
      7'h77:   res = {1'b0, 4'hA};
      7'h7c:   res = {1'b0, 4'hB};
      7'h59:   res = {1'b0, 4'hC};
      7'h3e:   res = {1'b0, 4'hD};
      7'h79:   res = {1'b0, 4'hE};
      7'h71:   res = {1'b0, 4'hF};
      default: res = {1'b1, 4'h0};
    endcase
    return res;
  endfunction

  // Sampling and stability qualification
  always_comb begin
    segs_cmp   = i_segs[SEG_W-1:0];
    seg_prev_d = segs_cmp;
    sel_prev_d = i_digitSel;
    sel_onehot = $onehot(i_digitSel);
    run_match  = sel_onehot && (segs_cmp == seg_prev_q) && (i_digitSel == sel_prev_q);
    if (!run_match) begin
      run_cnt_d = 8'd0;
    end else if (run_cnt_q == CNT_MAX) begin
      run_cnt_d = CNT_MAX;
    end else begin
      run_cnt_d = run_cnt_q + 8'd1;
    end
    cap_fire = run_match && (run_cnt_q == CNT_FIRE);
    {dec_err, dec_nib} = seg_decode(i_segs[6:0]);
  end

  // Captures only count while collecting; in PRESENT (including the accept
  // edge) they are dropped and the digit must be shown stable again.
  always_comb begin
    cap_en        = cap_fire && (state_q == ST_COLLECT);
    captured_next = captured_q | (cap_en ? i_digitSel : '0);
    all_captured  = &captured_next;
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (all_captured) state_d = ST_PRESENT;
      ST_PRESENT: if (i_ready)      state_d = ST_COLLECT;
      default:                      state_d = ST_COLLECT;
    endcase
  end

  // FSM: datapath updates
  always_comb begin
    value_d    = value_q;
    err_d      = err_q;
    dp_d       = dp_q;
    captured_d = captured_q;
    if (cap_en) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (i_digitSel[k]) begin
          value_d[4*k +: 4] = dec_nib;
          err_d[k]          = dec_err;
          dp_d[k]           = i_segs[7];
        end
      end
      captured_d = captured_next;
    end
    if ((state_q == ST_PRESENT) && i_ready) begin
      captured_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seg_prev_q <= '0;
      sel_prev_q <= '0;
      run_cnt_q  <= '0;
      captured_q <= '0;
      value_q    <= '0;
      err_q      <= '0;
      dp_q       <= '0;
    end else begin
      seg_prev_q <= seg_prev_d;
      sel_prev_q <= sel_prev_d;
      run_cnt_q  <= run_cnt_d;
      captured_q <= captured_d;
      value_q    <= value_d;
      err_q      <= err_d;
      dp_q       <= dp_d;
    end
  end

  assign o_value   = value_q;
  assign o_errMask = err_q;
  assign o_valid   = (state_q == ST_PRESENT);

`ifdef SEG_SCAN_READER_DP_EN
  assign o_dpMask = dp_q;
`else
  // dp capture has no consumer without the optional port.
  logic [NUM_DIGITS-1:0] unused_dp;
  assign unused_dp = dp_q;
`endif

endmodule

// File: tb/tb_seg_scan_reader.sv
module tb_seg_scan_reader;

  localparam int ND = 4;
  localparam int SC = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [7:0]    i_segs;
  logic [ND-1:0] i_digitSel;
  logic          i_ready;
  logic [4*ND-1:0] o_value;
  logic [ND-1:0] o_errMask;
  logic          o_valid;
`ifdef SEG_SCAN_READER_DP_EN
  logic [ND-1:0] o_dpMask;
`endif

  seg_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_segs     (i_segs),
    .i_digitSel (i_digitSel),
    .o_value    (o_value),
    .o_errMask  (o_errMask),
`ifdef SEG_SCAN_READER_DP_EN
    .o_dpMask   (o_dpMask),
`endif
    .o_valid    (o_valid),
    .i_ready    (i_ready)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] pat_tab [16] = '{8'h5f, 8'h06, 8'h3b, 8'h2f, 8'h66, 8'h6d, 8'h7d, 8'h07,
                               8'h7f, 8'h6f, 8'h77, 8'h7c, 8'h59, 8'h3e, 8'h79, 8'h71};

  // Reference model: length of the current run of identical one-hot cycles,
  // plus the frame contents.
  logic [7:0]      m_prev_seg;
  logic [ND-1:0]   m_prev_sel;
  int              m_len;
  bit              m_valid;
  logic [4*ND-1:0] m_value;
  logic [ND-1:0]   m_err;
  logic [ND-1:0]   m_cap;
  logic [ND-1:0]   m_dp;

  task automatic model_reset();
    m_prev_seg = '0; m_prev_sel = '0; m_len = 0; m_valid = 0;
    m_value = '0; m_err = '0; m_cap = '0; m_dp = '0;
  endtask

  task automatic model_step();
    logic [7:0] cmp;
    bit onehot, same, fire, err;
    int nib;
`ifdef SEG_SCAN_READER_DP_EN
    cmp = i_segs;
`else
    cmp = {1'b0, i_segs[6:0]};
`endif
    onehot = ($countones(i_digitSel) == 1);
    same   = onehot && (cmp == m_prev_seg) && (i_digitSel == m_prev_sel);
    if (same) m_len = m_len + 1;
    else      m_len = onehot ? 1 : 0;
    fire = (m_len == SC);
    m_prev_seg = cmp;
    m_prev_sel = i_digitSel;
    nib = 0; err = 1;
    for (int i = 0; i < 16; i++)
      if (i_segs[6:0] == pat_tab[i][6:0]) begin nib = i; err = 0; end
    if (m_valid) begin
      if (i_ready) begin m_valid = 0; m_cap = '0; end
    end else if (fire) begin
      for (int k = 0; k < ND; k++) begin
        if (i_digitSel[k]) begin
          m_value[4*k +: 4] = 4'(nib);
          m_err[k] = err;
          m_dp[k]  = i_segs[7];
          m_cap[k] = 1'b1;
        end
      end
      if (&m_cap) m_valid = 1;
    end
  endtask

  task automatic chk_outputs();
    checks++;
    assert (o_value === m_value) else begin
      errors++; $error("FAIL value got %h exp %h", o_value, m_value);
    end
    checks++;
    assert (o_errMask === m_err) else begin
      errors++; $error("FAIL errMask got %h exp %h", o_errMask, m_err);
    end
    checks++;
    assert (o_valid === m_valid) else begin
      errors++; $error("FAIL valid got %b exp %b", o_valid, m_valid);
    end
`ifdef SEG_SCAN_READER_DP_EN
    checks++;
    assert (o_dpMask === m_dp) else begin
      errors++; $error("FAIL dpMask got %h exp %h", o_dpMask, m_dp);
    end
`endif
  endtask

  task automatic expect_valid(input string tag, input logic exp);
    checks++;
    assert (o_valid === exp) else begin
      errors++; $error("FAIL %s valid got %b exp %b", tag, o_valid, exp);
    end
  endtask

  task automatic expect_frame(input string tag, input logic [4*ND-1:0] val, input logic [ND-1:0] err);
    checks++;
    assert (o_value === val) else begin
      errors++; $error("FAIL %s value got %h exp %h", tag, o_value, val);
    end
    checks++;
    assert (o_errMask === err) else begin
      errors++; $error("FAIL %s errMask got %h exp %h", tag, o_errMask, err);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    model_step();
    #1;
    chk_outputs();
  endtask

  task automatic hold(input logic [7:0] s, input logic [ND-1:0] sel, input int n, input logic rdy);
    i_segs = s; i_digitSel = sel; i_ready = rdy;
    repeat (n) cyc();
  endtask

  task automatic digit(input int k, input logic [7:0] s);
    hold(s, ND'(1 << k), SC, 1'b0);
  endtask

  task automatic accept();
    hold(8'h00, '0, 1, 1'b1);
    expect_valid("accept", 1'b0);
  endtask

  initial begin
    logic [7:0] s;
    logic [ND-1:0] sel;
    int n;
    logic rdy;

    i_rst_n = 1'b0; i_segs = '0; i_digitSel = '0; i_ready = 1'b0;
    model_reset();
    #2;
    chk_outputs();
    expect_frame("reset", '0, '0);
    #10;
    i_rst_n = 1'b1;

    // Four digits, four cycles each: valid rises on the 16th edge.
    digit(0, 8'h6d); digit(1, 8'h07); digit(2, 8'h59);
    hold(8'h7f, 4'b1000, 3, 1'b0);
    expect_valid("edge15", 1'b0);
    hold(8'h7f, 4'b1000, 1, 1'b0);
    expect_valid("edge16", 1'b1);
    expect_frame("frame1", 16'h8C75, 4'h0);
    accept();

    // Digit 1 held only three cycles is not captured.
    digit(0, 8'h5f);
    hold(8'h06, 4'b0010, 3, 1'b0);
    digit(2, 8'h3b); digit(3, 8'h2f);
    expect_valid("short_hold", 1'b0);
    digit(1, 8'h06);
    expect_valid("short_fixed", 1'b1);
    expect_frame("frame2", 16'h3210, 4'h0);
    accept();

    // Undecodable pattern on digit 2.
    digit(0, 8'h06); digit(1, 8'h06); digit(2, 8'h40); digit(3, 8'h06);
    expect_frame("errframe", 16'h1011, 4'h4);
    accept();

    // Two select bits never capture.
    digit(0, 8'h7d);
    hold(8'h7f, 4'b0011, 20, 1'b0);
    expect_valid("multisel", 1'b0);
    digit(1, 8'h66); digit(2, 8'h77); digit(3, 8'h71);
    expect_frame("frame4", 16'hFA46, 4'h0);

    // Frame held while the bus keeps moving and ready is low.
    for (int i = 0; i < 10; i++) begin
      hold(pat_tab[$urandom_range(0, 15)], ND'(1 << $urandom_range(0, ND-1)), 1, 1'b0);
      expect_frame("held", 16'hFA46, 4'h0);
    end
    accept();
    digit(0, 8'h06); digit(1, 8'h06); digit(2, 8'h06);
    expect_valid("refill", 1'b0);
    digit(3, 8'h06);
    expect_frame("frame5", 16'h1111, 4'h0);
    accept();

    // Asynchronous reset mid-hold of digit 2.
    digit(0, 8'h06); digit(1, 8'h5f);
    hold(8'h3b, 4'b0100, 2, 1'b0);
    #1 i_rst_n = 1'b0;
    #1;
    model_reset();
    chk_outputs();
    expect_frame("midreset", '0, '0);
    #2 i_rst_n = 1'b1;
    digit(0, 8'h06); digit(1, 8'h5f); digit(2, 8'h3b);
    expect_valid("post_reset", 1'b0);
    digit(3, 8'hEF);
    expect_frame("frame6", 16'h9201, 4'h0);
`ifdef SEG_SCAN_READER_DP_EN
    checks++;
    assert (o_dpMask === 4'h8) else begin
      errors++; $error("FAIL dp8 dpMask got %h exp %h", o_dpMask, 4'h8);
    end
`endif
    accept();

    // Randomized traffic against the model.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 99) < 85) sel = ND'(1 << $urandom_range(0, ND-1));
      else if ($urandom_range(0, 1) == 0) sel = '0;
      else sel = ND'(4'b0101 << $urandom_range(0, 1));
      if ($urandom_range(0, 99) < 80) s = pat_tab[$urandom_range(0, 15)] | {$urandom_range(0, 1) == 1, 7'h00};
      else s = 8'($urandom_range(0, 255));
      n   = $urandom_range(1, 7);
      rdy = ($urandom_range(0, 99) < 30);
      hold(s, sel, n, rdy);
      if ($urandom_range(0, 9) == 0) hold(s ^ 8'h80, sel, n, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
